// File: rtl/param_twisted_ring_counter.sv
// Parameterised twisted-ring (Johnson) / one-hot ring counter.
// q and idx are registered together so idx always names the position of q
// in its sequence. Illegal states (from an illegal load value or an upset)
// are steered back to the reset state with a one-cycle err pulse.
module param_twisted_ring_counter #(
  parameter int WIDTH = 4,
  parameter int MODE  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             dir,
  input  logic                             load,
  input  logic [WIDTH-1:0]                 load_val,
  output logic [WIDTH-1:0]                 q,
  output logic [$clog2(2*WIDTH)-1:0]       idx,
  output logic                             wrap,
  output logic                             err
);

  localparam int IDXW    = $clog2(2*WIDTH);
  localparam int NSTATES = (MODE == 1) ? 2*WIDTH : WIDTH;
  localparam logic [WIDTH-1:0] Q0 = (MODE == 1) ? '0 : WIDTH'(1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NSTATES-1);

  logic [WIDTH-1:0] r_q;
  logic [IDXW-1:0]  r_idx;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_err_nxt;

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Johnson codes are exactly the words with at most one 0/1 boundary
  // between adjacent bits; one-hot codes have exactly one bit set.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    int t;
    t = 0;
    if (MODE == 1) begin
      for (int i = 0; i < WIDTH-1; i++) begin
        if (v[i] != v[i+1]) t++;
      end
      return (t <= 1);
    end
    return (popcount(v) == 1);
  endfunction

  function automatic logic [IDXW-1:0] index_of(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    if (MODE == 1) begin
      if (v[0]) n = popcount(v);
      else      n = (2*WIDTH - popcount(v)) % (2*WIDTH);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) n = i;
      end
    end
    return IDXW'(n);
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                            input logic d);
    if (MODE == 1) begin
      if (d) return {~v[0], v[WIDTH-1:1]};
      return {v[WIDTH-2:0], ~v[WIDTH-1]};
    end
    if (d) return {v[0], v[WIDTH-1:1]};
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Next-state selection: load, then illegal-state recovery, then step, else hold.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (load) begin
      if (is_legal(load_val)) begin
        w_q_nxt = load_val;
      end else begin
        w_q_nxt   = Q0;
        w_err_nxt = 1'b1;
      end
    end else if (!is_legal(r_q)) begin
      w_q_nxt   = Q0;
      w_err_nxt = 1'b1;
    end else if (en) begin
      w_q_nxt    = step(r_q, dir);
      w_wrap_nxt = dir ? (r_idx == '0) : (r_idx == IDX_LAST);
    end
  end

  // State, index and status pulses, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= Q0;
      r_idx  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_idx  <= index_of(w_q_nxt);
      r_wrap <= w_wrap_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign q    = r_q;
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule
